cuila_capture: RTL and testbench

- Parametrised successor to the fixed-probe core logic analyzer.
- Samples CHANNELS probe words of DATA_W bits each cycle probe_valid is high (decoder/ALU buses) into a circular buffer.
- A programmable trigger on one selected channel freezes a window of PRE_DEPTH pre-trigger and DEPTH-PRE_DEPTH post-trigger samples (trigger sample included in post).
- Captured window is then drained oldest-first over a valid/ready read port to the debug host.

---
 rtl/cuila_capture.sv | 189 ++++++++++++++++++
 tb/tb_cuila_capture.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cuila_capture.sv
// Parametrised capture core: circular sample buffer, programmable trigger, valid/ready readout.
// Optional macro CUILA_TIMESTAMP_EN stores a 32-bit cycle stamp with each sample (rd_timestamp).
module cuila_capture #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned PRE_DEPTH = 16
) (
  input  logic                                             clk,
  input  logic                                             resetn,
  input  logic                                             probe_valid,
  input  logic [CHANNELS*DATA_W-1:0]                       probe_data,
  input  logic                                             arm,
  input  logic                                             abort,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] trig_sel,
  input  logic [1:0]                                       trig_mode,
  input  logic [DATA_W-1:0]                                trig_mask,
  input  logic [DATA_W-1:0]                                trig_value,
  output logic                                             busy,
  output logic                                             triggered,
  output logic                                             done,
  output logic                                             rd_valid,
  input  logic                                             rd_ready,
  output logic [CHANNELS*DATA_W-1:0]                       rd_data,
  output logic [$clog2(DEPTH)-1:0]                         rd_index,
  output logic                                             rd_last
`ifdef CUILA_TIMESTAMP_EN
  ,
  output logic [31:0]                                      rd_timestamp
`endif
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned ProbeW = CHANNELS * DATA_W;
`ifdef CUILA_TIMESTAMP_EN
  localparam int unsigned MemW   = ProbeW + 32;
`else
  localparam int unsigned MemW   = ProbeW;
`endif
  localparam int unsigned PostN  = DEPTH - PRE_DEPTH - 1;

  typedef enum logic [2:0] {StIdle, StFill, StWait, StPost, StDone, StRead} state_e;

  state_e               state_q;
  logic [AddrW-1:0]     wptr_q, cnt_q, trig_ptr_q;
  logic [DATA_W-1:0]    prev_q;
  logic                 prev_ok_q;
  logic [MemW-1:0]      rd_word_q;
  logic [MemW-1:0]      mem [DEPTH];
  logic [MemW-1:0]      wdata;
  logic [DATA_W-1:0]    ch_val;
  logic                 hit, store;
  logic [AddrW-1:0]     start_addr, next_addr;

  // Out-of-range selects fall through to channel 0.
  always_comb begin
    ch_val = probe_data[DATA_W-1:0];
    for (int unsigned k = 1; k < CHANNELS; k++) begin
      if (32'(trig_sel) == k) ch_val = probe_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    case (trig_mode)
      2'd0:    hit = ((ch_val ^ trig_value) & trig_mask) == '0;
      2'd1:    hit = ((ch_val ^ trig_value) & trig_mask) != '0;
      2'd2:    hit = prev_ok_q && (((ch_val ^ prev_q) & trig_mask) != '0);
      default: hit = 1'b0;
    endcase
  end

  assign store      = probe_valid && (state_q inside {StFill, StWait, StPost});
  assign start_addr = trig_ptr_q - AddrW'(PRE_DEPTH);
  assign next_addr  = start_addr + rd_index + AddrW'(1);
  assign rd_data    = rd_word_q[ProbeW-1:0];

`ifdef CUILA_TIMESTAMP_EN
  logic [31:0] ts_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ts_q <= '0;
    else         ts_q <= ts_q + 32'd1;
  end
  assign wdata        = {ts_q, probe_data};
  assign rd_timestamp = rd_word_q[MemW-1 -: 32];
`else
  assign wdata = probe_data;
`endif

  always_ff @(posedge clk) begin
    if (store) mem[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      cnt_q      <= '0;
      trig_ptr_q <= '0;
      prev_q     <= '0;
      prev_ok_q  <= 1'b0;
      busy       <= 1'b0;
      triggered  <= 1'b0;
      done       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_index   <= '0;
      rd_word_q  <= '0;
    end else if (abort) begin
      state_q   <= StIdle;
      busy      <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_index  <= '0;
    end else if (arm && (state_q == StIdle || state_q == StDone)) begin
      // A pending (unread) window is discarded on re-arm.
      state_q   <= (PRE_DEPTH == 0) ? StWait : StFill;
      wptr_q    <= '0;
      cnt_q     <= '0;
      prev_ok_q <= 1'b0;
      busy      <= 1'b1;
      triggered <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (store) begin
        wptr_q    <= wptr_q + AddrW'(1);
        prev_q    <= ch_val;
        prev_ok_q <= 1'b1;
      end
      case (state_q)
        StIdle: state_q <= StIdle;
        StFill: if (probe_valid) begin
          if (32'(cnt_q) + 32'd1 == PRE_DEPTH) begin
            cnt_q   <= '0;
            state_q <= StWait;
          end else begin
            cnt_q <= cnt_q + AddrW'(1);
          end
        end
        StWait: if (probe_valid && hit) begin
          trig_ptr_q <= wptr_q;
          triggered  <= 1'b1;
          if (PostN == 0) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_q <= StPost;
          end
        end
        StPost: if (probe_valid) begin
          if (32'(cnt_q) + 32'd1 == PostN) begin
            cnt_q   <= '0;
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + AddrW'(1);
          end
        end
        StDone: begin
          rd_word_q <= mem[start_addr];
          rd_valid  <= 1'b1;
          rd_index  <= '0;
          rd_last   <= 1'b0;
          state_q   <= StRead;
        end
        StRead: if (rd_ready) begin
          if (rd_last) begin
            state_q   <= StIdle;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_index  <= '0;
            done      <= 1'b0;
            triggered <= 1'b0;
          end else begin
            // Prefetch the next word so back-to-back handshakes run at full rate.
            rd_index  <= rd_index + AddrW'(1);
            rd_last   <= (rd_index == AddrW'(DEPTH - 2));
            rd_word_q <= mem[next_addr];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cuila_capture.sv
// Bench for cuila_capture: three instances (PRE 2, 0, 7; DEPTH 8, 2 channels) share stimulus;
// expected windows come from a sample-history model searched for the first trigger hit.
module tb_cuila_capture;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        probe_valid = 1'b0;
  logic [63:0] probe_data = '0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [0:0]  trig_sel = '0;
  logic [1:0]  trig_mode = '0;
  logic [31:0] trig_mask = '0;
  logic [31:0] trig_value = '0;
  logic        rd_ready = 1'b0;

  logic        busy_a [N];
  logic        triggered_a [N];
  logic        done_a [N];
  logic        rd_valid_a [N];
  logic        rd_last_a [N];
  logic [63:0] rd_data_a [N];
  logic [2:0]  rd_index_a [N];
`ifdef CUILA_TIMESTAMP_EN
  logic [31:0] ts_a [N];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned P = (g == 0) ? 2 : ((g == 1) ? 0 : 7);
    cuila_capture #(.DATA_W(32), .CHANNELS(2), .DEPTH(8), .PRE_DEPTH(P)) u_dut (
      .clk(clk), .resetn(resetn), .probe_valid(probe_valid), .probe_data(probe_data),
      .arm(arm), .abort(abort), .trig_sel(trig_sel), .trig_mode(trig_mode),
      .trig_mask(trig_mask), .trig_value(trig_value), .busy(busy_a[g]),
      .triggered(triggered_a[g]), .done(done_a[g]), .rd_valid(rd_valid_a[g]),
      .rd_ready(rd_ready), .rd_data(rd_data_a[g]), .rd_index(rd_index_a[g]),
      .rd_last(rd_last_a[g])
`ifdef CUILA_TIMESTAMP_EN
      , .rd_timestamp(ts_a[g])
`endif
    );
  end

  // Every valid sample since the latest arm, in arrival order.
  logic [63:0] hist [$];
  always @(posedge clk) begin
    if (resetn) begin
      if (arm) hist.delete();
      else if (probe_valid) hist.push_back(probe_data);
    end
  end

  int          n_chk = 0;
  int          n_fail = 0;
  bit          started [N];
  bit          complete [N];
  int          rd_idx [N];
  int          tpos [N];
  logic [31:0] first_w [N];
  logic [31:0] last_w [N];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic int pre_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 7);
  endfunction

  function automatic logic [31:0] pick(input logic [63:0] s);
    return trig_sel[0] ? s[63:32] : s[31:0];
  endfunction

  // First sample index (not before PRE) that satisfies the trigger rule, or -1.
  function automatic int model_trigger(input int pre);
    for (int t = pre; t < hist.size(); t++) begin
      case (trig_mode)
        2'd0: if (((pick(hist[t]) ^ trig_value) & trig_mask) == 0) return t;
        2'd1: if (((pick(hist[t]) ^ trig_value) & trig_mask) != 0) return t;
        2'd2: if (t > 0 && ((pick(hist[t]) ^ pick(hist[t-1])) & trig_mask) != 0) return t;
        default: ;
      endcase
    end
    return -1;
  endfunction

  function automatic bit all_done();
    for (int k = 0; k < N; k++) if (!complete[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cmp_cycle();
    if (!resetn) return;
    for (int k = 0; k < N; k++) begin
      if (rd_valid_a[k]) begin
        int pos;
        if (!started[k]) begin
          started[k] = 1'b1;
          tpos[k]    = model_trigger(pre_of(k));
        end
        pos = tpos[k] - pre_of(k) + rd_idx[k];
        if (tpos[k] < 0 || pos < 0 || pos >= hist.size()) begin
          chk($sformatf("dut%0d_window_known", k), 1'b0, 1'b1);
        end else begin
          chk($sformatf("dut%0d_rd_data[%0d]", k, rd_idx[k]), rd_data_a[k], hist[pos]);
        end
        chk($sformatf("dut%0d_rd_index", k), 64'(rd_index_a[k]), 64'(rd_idx[k]));
        chk($sformatf("dut%0d_rd_last", k), 64'(rd_last_a[k]), 64'(rd_idx[k] == 7));
        chk($sformatf("dut%0d_done_in_read", k), 64'(done_a[k]), 64'd1);
        chk($sformatf("dut%0d_busy_in_read", k), 64'(busy_a[k]), 64'd0);
        if (rd_ready) begin
          if (rd_idx[k] == 0) first_w[k] = rd_data_a[k][31:0];
          if (rd_idx[k] == 7) begin
            last_w[k]   = rd_data_a[k][31:0];
            started[k]  = 1'b0;
            rd_idx[k]   = 0;
            complete[k] = 1'b1;
          end else begin
            rd_idx[k]++;
          end
        end
      end
    end
  endtask

  // Inputs change on the falling edge; the compare sees the rd_ready the next rise will sample.
  task automatic tick(input logic a, input logic ab, input logic pv, input logic [63:0] pd,
                      input logic rdy);
    @(negedge clk);
    arm = a; abort = ab; probe_valid = pv; probe_data = pd; rd_ready = rdy;
    cmp_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_dut%0d_busy", tag, k), 64'(busy_a[k]), 64'd0);
      chk($sformatf("%s_dut%0d_triggered", tag, k), 64'(triggered_a[k]), 64'd0);
      chk($sformatf("%s_dut%0d_done", tag, k), 64'(done_a[k]), 64'd0);
      chk($sformatf("%s_dut%0d_rd_valid", tag, k), 64'(rd_valid_a[k]), 64'd0);
      chk($sformatf("%s_dut%0d_rd_last", tag, k), 64'(rd_last_a[k]), 64'd0);
      chk($sformatf("%s_dut%0d_rd_data", tag, k), rd_data_a[k], 64'd0);
      chk($sformatf("%s_dut%0d_rd_index", tag, k), 64'(rd_index_a[k]), 64'd0);
    end
  endtask

  // ch0 carries the sample number; ch1 is 1, or steps 0 -> 1 at sample 20.
  function automatic logic [63:0] sample(input int pc, input bit ch1_step);
    logic [31:0] c1;
    c1 = ch1_step ? ((pc >= 20) ? 32'd1 : 32'd0) : 32'd1;
    return {c1, 32'(pc)};
  endfunction

  task automatic capture(input string tag, input bit toggle, input bit ch1_step);
    int pc;
    pc = 0;
    for (int k = 0; k < N; k++) complete[k] = 1'b0;
    tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
    for (int c = 0; c < 300 && !all_done(); c++) begin
      tick(1'b0, 1'b0, 1'b1, sample(pc, ch1_step), toggle ? 1'(c % 2 == 0) : 1'b1);
      pc++;
    end
    chk({tag, "_all_windows_read"}, 64'(all_done()), 64'd1);
  endtask

  task automatic check_lits(input string tag, input int f0, input int l0, input int f1,
                            input int f2, input int l2);
    chk({tag, "_pre2_first"}, 64'(first_w[0]), 64'(f0));
    chk({tag, "_pre2_last"}, 64'(last_w[0]), 64'(l0));
    chk({tag, "_pre0_first"}, 64'(first_w[1]), 64'(f1));
    chk({tag, "_pre7_first"}, 64'(first_w[2]), 64'(f2));
    chk({tag, "_pre7_last"}, 64'(last_w[2]), 64'(l2));
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      started[k] = 1'b0; complete[k] = 1'b0; rd_idx[k] = 0; tpos[k] = -1;
      first_w[k] = '0; last_w[k] = '0;
    end
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Equal-match on ch0 == 10.
    trig_sel = 1'b0; trig_mode = 2'd0; trig_mask = 32'hFFFF_FFFF; trig_value = 32'd10;
    capture("s1", 1'b0, 1'b0);
    check_lits("s1", 8, 15, 10, 3, 10);

    // Same capture with rd_ready toggling every cycle.
    capture("s2", 1'b1, 1'b0);
    check_lits("s2", 8, 15, 10, 3, 10);

    // Change mode on ch1 bit 0; stale history from s2 (ch1 = 1) must not fire at sample 0.
    trig_sel = 1'b1; trig_mode = 2'd2; trig_mask = 32'h1; trig_value = 32'd0;
    capture("s3", 1'b0, 1'b1);
    check_lits("s3", 18, 25, 20, 13, 20);

    // Reserved mode never fires even with an all-zero mask; then abort.
    trig_sel = 1'b0; trig_mode = 2'd3; trig_mask = 32'h0;
    tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
    for (int c = 0; c < 40; c++) tick(1'b0, 1'b0, 1'b1, sample(c, 1'b0), 1'b1);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("s4_dut%0d_busy_waiting", k), 64'(busy_a[k]), 64'd1);
      chk($sformatf("s4_dut%0d_no_done", k), 64'(done_a[k]), 64'd0);
      chk($sformatf("s4_dut%0d_not_triggered", k), 64'(triggered_a[k]), 64'd0);
    end
    tick(1'b0, 1'b1, 1'b1, '0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int k = 0; k < N; k++)
      chk($sformatf("s4_dut%0d_busy_after_abort", k), 64'(busy_a[k]), 64'd0);

    // Park every instance in READ with rd_ready low, then reset asynchronously.
    trig_mode = 2'd0; trig_mask = 32'hFFFF_FFFF; trig_value = 32'd10;
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    begin
      int pc;
      bit all_valid;
      pc = 0;
      all_valid = 1'b0;
      for (int c = 0; c < 100 && !all_valid; c++) begin
        tick(1'b0, 1'b0, 1'b1, sample(pc, 1'b0), 1'b0);
        pc++;
        all_valid = rd_valid_a[0] && rd_valid_a[1] && rd_valid_a[2];
      end
      chk("s5_reached_read", 64'(all_valid), 64'd1);
    end
    tick(1'b0, 1'b0, 1'b1, sample(50, 1'b0), 1'b0);
    #2 resetn = 1'b0;
    #1;
    check_reset_outputs("s5_async_reset");
    for (int k = 0; k < N; k++) begin
      started[k] = 1'b0; rd_idx[k] = 0;
    end
    repeat (2) tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    capture("s6", 1'b0, 1'b0);
    check_lits("s6", 8, 15, 10, 3, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
